// File: rtl/program_result_monitor.sv
// End-of-program monitor on the data-memory bus. It decides PASS/FAIL from the result-word store
// and also catches out-of-program fetches and watchdog expiry.
module program_result_monitor #(
    parameter int                XLEN           = 32,
    parameter logic [XLEN-1:0]   RESULT_ADR     = 'hC,
    parameter logic [XLEN-1:0]   EXPECTED_VALUE = 'h0F,
    parameter int                PROGRAM_WORDS  = 64,
    parameter int                MAX_CYCLES     = 10000,
    parameter int                COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemEn,
    input  logic                   MemWriteEn,
    input  logic [XLEN-1:0]        MemAdr,
    input  logic [XLEN-1:0]        MemWriteData,
    input  logic [XLEN-1:0]        InstrAdr,
    output logic [2:0]             Status,
    output logic                   Done,
    output logic                   Pass,
    output logic [XLEN-1:0]        ResultValue,
    output logic [XLEN-1:0]        FinalInstrAdr,
    output logic [COUNT_WIDTH-1:0] CycleCount,
    output logic [COUNT_WIDTH-1:0] StoreCount
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_OOP     = 3'd4
    } status_e;

    // One extra bit so a fetch limit equal to 2**XLEN never wraps to zero.
    localparam longint            FETCH_BYTES = longint'(PROGRAM_WORDS) * 4;
    localparam logic [XLEN:0]     FETCH_LIMIT = (XLEN+1)'(FETCH_BYTES);
    localparam logic [COUNT_WIDTH-1:0] WDOG_LAST = COUNT_WIDTH'(MAX_CYCLES - 1);

    status_e                status_q, status_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [XLEN-1:0]        result_q, result_d;
    logic [XLEN-1:0]        final_adr_q, final_adr_d;
    logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [COUNT_WIDTH-1:0] store_cnt_q, store_cnt_d;

    logic is_store, is_hit, is_oop, is_wdog;

    always_comb begin
        is_store = MemEn & MemWriteEn;
        is_hit   = is_store & (MemAdr == RESULT_ADR);
        is_oop   = ({1'b0, InstrAdr} >= FETCH_LIMIT);
        is_wdog  = (cycle_q == WDOG_LAST);
    end

    always_comb begin
        status_d    = status_q;
        result_d    = result_q;
        final_adr_d = final_adr_q;
        cycle_d     = cycle_q;
        store_cnt_d = store_cnt_q;

        // Terminal states hold everything; only RUN advances.
        if (status_q == ST_RUN) begin
            if (cycle_q != '1) begin
                cycle_d = cycle_q + COUNT_WIDTH'(1);
            end
            if (is_store && (store_cnt_q != '1)) begin
                store_cnt_d = store_cnt_q + COUNT_WIDTH'(1);
            end

            if (is_hit) begin
                result_d    = MemWriteData;
                final_adr_d = InstrAdr;
                status_d    = (MemWriteData == EXPECTED_VALUE) ? ST_PASS : ST_FAIL;
            end else if (is_oop) begin
                final_adr_d = InstrAdr;
                status_d    = ST_OOP;
            end else if (is_wdog) begin
                final_adr_d = InstrAdr;
                status_d    = ST_TIMEOUT;
            end
        end

        done_d = (status_d != ST_RUN);
        pass_d = (status_d == ST_PASS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q    <= ST_RUN;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            result_q    <= '0;
            final_adr_q <= '0;
            cycle_q     <= '0;
            store_cnt_q <= '0;
        end else begin
            status_q    <= status_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            result_q    <= result_d;
            final_adr_q <= final_adr_d;
            cycle_q     <= cycle_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign Status        = status_q;
    assign Done          = done_q;
    assign Pass          = pass_q;
    assign ResultValue   = result_q;
    assign FinalInstrAdr = final_adr_q;
    assign CycleCount    = cycle_q;
    assign StoreCount    = store_cnt_q;

endmodule

// File: tb/tb_program_result_monitor.sv
// Bench for program_result_monitor: directed scenarios plus random traffic checked against a
// history-scan model, on a default instance and a short-watchdog instance.
module tb_program_result_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemEn, MemWriteEn;
    logic [31:0] MemAdr, MemWriteData, InstrAdr;

    logic [2:0]  st_o   [2];
    logic        done_o [2];
    logic        pass_o [2];
    logic [31:0] res_o  [2];
    logic [31:0] fadr_o [2];
    logic [31:0] cyc_o  [2];
    logic [31:0] stc_o  [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;
        logic [31:0] iadr;
    } stim_t;

    typedef struct {
        logic [2:0]  status;
        logic [31:0] result;
        logic [31:0] final_adr;
        logic [31:0] cycles;
        logic [31:0] stores;
    } exp_t;

    stim_t hist[$];

    always #5 clk = ~clk;

    program_result_monitor dut_a (
        .clk(clk), .reset(reset), .MemEn(MemEn), .MemWriteEn(MemWriteEn),
        .MemAdr(MemAdr), .MemWriteData(MemWriteData), .InstrAdr(InstrAdr),
        .Status(st_o[0]), .Done(done_o[0]), .Pass(pass_o[0]), .ResultValue(res_o[0]),
        .FinalInstrAdr(fadr_o[0]), .CycleCount(cyc_o[0]), .StoreCount(stc_o[0])
    );

    program_result_monitor #(.MAX_CYCLES(20)) dut_b (
        .clk(clk), .reset(reset), .MemEn(MemEn), .MemWriteEn(MemWriteEn),
        .MemAdr(MemAdr), .MemWriteData(MemWriteData), .InstrAdr(InstrAdr),
        .Status(st_o[1]), .Done(done_o[1]), .Pass(pass_o[1]), .ResultValue(res_o[1]),
        .FinalInstrAdr(fadr_o[1]), .CycleCount(cyc_o[1]), .StoreCount(stc_o[1])
    );

    // Expected outputs after all cycles in hist: find the first terminating cycle, if any.
    function automatic exp_t model(int max_cycles);
        exp_t e;
        int   t = -1;
        e = '{status: 3'd0, result: 32'd0, final_adr: 32'd0, cycles: 32'd0, stores: 32'd0};
        for (int i = 0; i < hist.size(); i++) begin
            logic hit = hist[i].en && hist[i].we && (hist[i].adr == 32'hC);
            if (hit || hist[i].iadr >= 32'h100 || i == max_cycles - 1) begin
                t = i;
                break;
            end
        end
        e.cycles = (t < 0) ? hist.size() : t + 1;
        for (int i = 0; i < int'(e.cycles); i++) begin
            if (hist[i].en && hist[i].we) e.stores++;
        end
        if (t >= 0) begin
            e.final_adr = hist[t].iadr;
            if (hist[t].en && hist[t].we && hist[t].adr == 32'hC) begin
                e.result = hist[t].data;
                e.status = (hist[t].data == 32'h0F) ? 3'd1 : 3'd2;
            end else if (hist[t].iadr >= 32'h100) begin
                e.status = 3'd4;
            end else begin
                e.status = 3'd3;
            end
        end
        return e;
    endfunction

    task automatic drive(input logic en, input logic we, input logic [31:0] adr,
                         input logic [31:0] data, input logic [31:0] iadr);
        stim_t s;
        s = '{en: en, we: we, adr: adr, data: data, iadr: iadr};
        MemEn = en; MemWriteEn = we; MemAdr = adr; MemWriteData = data; InstrAdr = iadr;
        @(posedge clk); #1;
        hist.push_back(s);
        $display("txn en=%0b we=%0b adr=%h data=%h iadr=%h -> A st=%0d cyc=%0d B st=%0d cyc=%0d",
                 en, we, adr, data, iadr, st_o[0], cyc_o[0], st_o[1], cyc_o[1]);
    endtask

    task automatic idle(input logic [31:0] iadr);
        drive(1'b0, 1'b0, 32'h0, 32'h0, iadr);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        MemEn = 1'b0; MemWriteEn = 1'b0; MemAdr = '0; MemWriteData = '0; InstrAdr = '0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        hist.delete();
    endtask

    task automatic test_reset;
        do_reset(2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (st_o[k] !== 3'd0 || done_o[k] !== 1'b0 || pass_o[k] !== 1'b0 ||
                res_o[k] !== 32'd0 || fadr_o[k] !== 32'd0 || cyc_o[k] !== 32'd0 || stc_o[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got st=%0d done=%0b pass=%0b res=%h fadr=%h cyc=%0d stc=%0d exp all zero",
                         k, st_o[k], done_o[k], pass_o[k], res_o[k], fadr_o[k], cyc_o[k], stc_o[k]);
            end
        end
    endtask

    task automatic run_pass_scenario(input string tag);
        repeat (5) idle(32'h10);
        drive(1'b1, 1'b1, 32'hC, 32'h0F, 32'h24);
        checks++;
        if (st_o[0] !== 3'd1 || pass_o[0] !== 1'b1 || done_o[0] !== 1'b1 || res_o[0] !== 32'h0F ||
            cyc_o[0] !== 32'd6 || stc_o[0] !== 32'd1 || fadr_o[0] !== 32'h24) begin
            errors++;
            $display("FAIL %s got st=%0d pass=%0b done=%0b res=%h cyc=%0d stc=%0d fadr=%h exp st=1 pass=1 done=1 res=0f cyc=6 stc=1 fadr=24",
                     tag, st_o[0], pass_o[0], done_o[0], res_o[0], cyc_o[0], stc_o[0], fadr_o[0]);
        end
    endtask

    task automatic test_pass;
        do_reset(2);
        run_pass_scenario("pass_basic");
        // Absorbing: further stores and fetches past the image change nothing.
        drive(1'b1, 1'b1, 32'hC, 32'h55, 32'h28);
        drive(1'b1, 1'b1, 32'h8, 32'h01, 32'h200);
        checks++;
        if (st_o[0] !== 3'd1 || res_o[0] !== 32'h0F || cyc_o[0] !== 32'd6 || stc_o[0] !== 32'd1 || fadr_o[0] !== 32'h24) begin
            errors++;
            $display("FAIL pass_frozen got st=%0d res=%h cyc=%0d stc=%0d fadr=%h exp st=1 res=0f cyc=6 stc=1 fadr=24",
                     st_o[0], res_o[0], cyc_o[0], stc_o[0], fadr_o[0]);
        end
    endtask

    task automatic test_fail;
        do_reset(2);
        drive(1'b1, 1'b1, 32'h8, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 32'hC, 32'h0E, 32'h4);
        checks++;
        if (st_o[0] !== 3'd2 || pass_o[0] !== 1'b0 || done_o[0] !== 1'b1 || res_o[0] !== 32'h0E || stc_o[0] !== 32'd2) begin
            errors++;
            $display("FAIL fail_result got st=%0d pass=%0b done=%0b res=%h stc=%0d exp st=2 pass=0 done=1 res=0e stc=2",
                     st_o[0], pass_o[0], done_o[0], res_o[0], stc_o[0]);
        end
        drive(1'b1, 1'b1, 32'hC, 32'h0F, 32'h8);
        checks++;
        if (st_o[0] !== 3'd2 || res_o[0] !== 32'h0E || pass_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL fail_repeat_hit got st=%0d res=%h pass=%0b exp st=2 res=0e pass=0",
                     st_o[0], res_o[0], pass_o[0]);
        end
    endtask

    task automatic test_no_terminate;
        do_reset(2);
        drive(1'b1, 1'b0, 32'hC, 32'h0F, 32'h0);
        drive(1'b0, 1'b1, 32'hC, 32'h0F, 32'h4);
        drive(1'b1, 1'b1, 32'hD, 32'h0F, 32'h8);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'hFC);
        checks++;
        if (st_o[0] !== 3'd0 || done_o[0] !== 1'b0 || stc_o[0] !== 32'd1 || cyc_o[0] !== 32'd4) begin
            errors++;
            $display("FAIL no_terminate got st=%0d done=%0b stc=%0d cyc=%0d exp st=0 done=0 stc=1 cyc=4",
                     st_o[0], done_o[0], stc_o[0], cyc_o[0]);
        end
    endtask

    task automatic test_oop;
        do_reset(2);
        idle(32'h0);
        idle(32'h100);
        checks++;
        if (st_o[0] !== 3'd4 || fadr_o[0] !== 32'h100 || res_o[0] !== 32'd0 || done_o[0] !== 1'b1 || cyc_o[0] !== 32'd2) begin
            errors++;
            $display("FAIL oop got st=%0d fadr=%h res=%h done=%0b cyc=%0d exp st=4 fadr=100 res=0 done=1 cyc=2",
                     st_o[0], fadr_o[0], res_o[0], done_o[0], cyc_o[0]);
        end
        do_reset(1);
        drive(1'b1, 1'b1, 32'hC, 32'h0F, 32'h100);
        checks++;
        if (st_o[0] !== 3'd1 || fadr_o[0] !== 32'h100 || res_o[0] !== 32'h0F || pass_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL oop_vs_hit got st=%0d fadr=%h res=%h pass=%0b exp st=1 fadr=100 res=0f pass=1",
                     st_o[0], fadr_o[0], res_o[0], pass_o[0]);
        end
    endtask

    task automatic test_watchdog;
        do_reset(2);
        for (int c = 1; c <= 19; c++) begin
            idle(32'(c * 4));
            checks++;
            if (st_o[1] !== 3'd0 || cyc_o[1] !== 32'(c)) begin
                errors++;
                $display("FAIL wdog_run c=%0d got st=%0d cyc=%0d exp st=0 cyc=%0d", c, st_o[1], cyc_o[1], c);
            end
        end
        idle(32'h50);
        checks++;
        if (st_o[1] !== 3'd3 || cyc_o[1] !== 32'd20 || fadr_o[1] !== 32'h50 || done_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL wdog_fire got st=%0d cyc=%0d fadr=%h done=%0b exp st=3 cyc=20 fadr=50 done=1",
                     st_o[1], cyc_o[1], fadr_o[1], done_o[1]);
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b1, 32'hC, 32'h0F, 32'h54);
            checks++;
            if (st_o[1] !== 3'd3 || cyc_o[1] !== 32'd20 || stc_o[1] !== 32'd0) begin
                errors++;
                $display("FAIL wdog_hold c=%0d got st=%0d cyc=%0d stc=%0d exp st=3 cyc=20 stc=0",
                         c, st_o[1], cyc_o[1], stc_o[1]);
            end
        end
        checks++;
        if (st_o[0] !== 3'd1) begin
            errors++;
            $display("FAIL wdog_default_inst got st=%0d exp st=1", st_o[0]);
        end
    endtask

    task automatic test_reset_midrun;
        do_reset(2);
        run_pass_scenario("pre_reset_pass");
        do_reset(1);
        checks++;
        if (st_o[0] !== 3'd0 || done_o[0] !== 1'b0 || pass_o[0] !== 1'b0 || res_o[0] !== 32'd0 ||
            fadr_o[0] !== 32'd0 || cyc_o[0] !== 32'd0 || stc_o[0] !== 32'd0) begin
            errors++;
            $display("FAIL reset_after_pass got st=%0d done=%0b pass=%0b res=%h fadr=%h cyc=%0d stc=%0d exp all zero",
                     st_o[0], done_o[0], pass_o[0], res_o[0], fadr_o[0], cyc_o[0], stc_o[0]);
        end
        run_pass_scenario("rerun_pass");
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            do_reset(1);
            for (int c = 0; c < 30; c++) begin
                logic [31:0] adr, data, iadr;
                exp_t        e;
                case ($urandom_range(0, 5))
                    0, 1:    adr = 32'hC;
                    2:       adr = 32'hD;
                    3:       adr = 32'h8;
                    default: adr = $urandom_range(0, 255);
                endcase
                data = ($urandom_range(0, 1) == 1) ? 32'h0F : $urandom;
                iadr = ($urandom_range(0, 24) == 0) ? 32'h100 + $urandom_range(0, 64) : 32'($urandom_range(0, 63) * 4);
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), adr, data, iadr);
                for (int k = 0; k < 2; k++) begin
                    e = model(k == 0 ? 10000 : 20);
                    checks++;
                    if (st_o[k] !== e.status || res_o[k] !== e.result || fadr_o[k] !== e.final_adr ||
                        cyc_o[k] !== e.cycles || stc_o[k] !== e.stores ||
                        done_o[k] !== (e.status != 3'd0) || pass_o[k] !== (e.status == 3'd1)) begin
                        errors++;
                        $display("FAIL random r=%0d c=%0d inst=%0d got st=%0d res=%h fadr=%h cyc=%0d stc=%0d done=%0b pass=%0b exp st=%0d res=%h fadr=%h cyc=%0d stc=%0d",
                                 r, c, k, st_o[k], res_o[k], fadr_o[k], cyc_o[k], stc_o[k], done_o[k], pass_o[k],
                                 e.status, e.result, e.final_adr, e.cycles, e.stores);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_no_terminate();
        test_oop();
        test_watchdog();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_result_monitor.md
Name: program_result_monitor

Overview:
- Synthesizable end-of-program monitor on the core's data-memory bus, downstream of the core's memory stage.
- Watches stores; declares PASS/FAIL when the program writes its result word to RESULT_ADR.
- Flags a fetch past the loaded program image and a watchdog timeout.
- Gives benches and FPGA builds one registered status instead of hierarchical probing.

Parameters:
- XLEN, `XLEN, data/address width.
- RESULT_ADR, 'hC, byte address of the result store.
- EXPECTED_VALUE, 'h0F, required result word.
- PROGRAM_WORDS, 64, instruction-memory depth in words; valid fetch range is 0 .. PROGRAM_WORDS*4-1.
- MAX_CYCLES, 10000, watchdog limit in RUN cycles (≥1).
- COUNT_WIDTH, 32, width of the cycle and store counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- MemEn  in  1  data-memory access valid.
- MemWriteEn  in  1  access is a store.
- MemAdr  in  XLEN  data-memory byte address.
- MemWriteData  in  XLEN  store data.
- InstrAdr  in  XLEN  current fetch address (PC).
- Status  out  3  0=RUN, 1=PASS, 2=FAIL, 3=TIMEOUT, 4=OUT_OF_PROGRAM.
- Done  out  1  Status != RUN.
- Pass  out  1  Status == PASS.
- ResultValue  out  XLEN  data of the terminating result store.
- FinalInstrAdr  out  XLEN  InstrAdr sampled in the terminating cycle.
- CycleCount  out  COUNT_WIDTH  RUN cycles elapsed.
- StoreCount  out  COUNT_WIDTH  stores observed in RUN.

Behaviour:
- One clock (clk); reset synchronous, active-high. All outputs registered; no combinational path from inputs to outputs.
- Reset (any state, including mid-program): next edge sets Status=RUN, Done=0, Pass=0, all data and counters 0.
- Events, evaluated only in RUN:
  - Store = MemEn & MemWriteEn. MemWriteEn without MemEn is ignored.
  - Hit = Store & (MemAdr == RESULT_ADR). Compare is full width and exact; other byte offsets of the same word do not hit.
  - OOP = InstrAdr >= PROGRAM_WORDS*4, compared unsigned.
  - Wdog = CycleCount == MAX_CYCLES-1.
- Every RUN cycle, including the terminating one:
  - CycleCount += 1, saturating at all-ones.
  - StoreCount += Store, saturating at all-ones.
- Transition priority within one cycle: Hit > OOP > Wdog.
  - Hit: ResultValue <= MemWriteData; FinalInstrAdr <= InstrAdr; Status <= PASS if MemWriteData == EXPECTED_VALUE, else FAIL.
  - OOP: FinalInstrAdr <= InstrAdr; ResultValue stays 0; Status <= OUT_OF_PROGRAM.
  - Wdog: FinalInstrAdr <= InstrAdr; Status <= TIMEOUT. CycleCount then reads MAX_CYCLES.
- Terminal states (PASS, FAIL, TIMEOUT, OUT_OF_PROGRAM) are absorbing until reset:
  - counters and captured values frozen;
  - further stores, including repeat hits, are ignored.
- Done and Pass update on the same edge as Status, one cycle after the triggering input cycle.
- Non-store accesses to RESULT_ADR (loads) never terminate.

Test Plan:
- Reset 2 cycles; 5 idle cycles; cycle 6 MemEn=1, MemWriteEn=1, MemAdr=0xC, data=0x0F -> Status=1, Pass=1, Done=1, ResultValue=0x0F, CycleCount=6, StoreCount=1.
- Store 0x10 to 0x8, then 0x0E to 0xC -> Status=2, Pass=0, ResultValue=0x0E, StoreCount=2; a later store of 0x0F to 0xC leaves Status=2.
- Load MemEn=1/MemWriteEn=0 to 0xC; MemEn=0/MemWriteEn=1 to 0xC; store to 0xD -> Status stays 0, StoreCount=1.
- InstrAdr=0x100 with PROGRAM_WORDS=64 -> Status=4, FinalInstrAdr=0x100. Repeated with a 0x0F store to 0xC in the same cycle -> Status=1.
- MAX_CYCLES=20, no stores -> Status=0 through cycle 19; after cycle 20 Status=3, CycleCount=20 and held for 10 more cycles.
- Reach PASS, then assert reset one cycle -> all outputs 0, Status=0; rerun first scenario -> identical results.
